// File: rtl/sprite_compositor.sv
// sprite_compositor: N-layer 1bpp-RGB sprite compositor for the VGA path.
// Ports: VGA_CLK/reset, active, VGA_X/VGA_Y counters, bitmap write port
// (bm_*), shadow attribute write port (at_*), VGA_R/G/B out, per-layer
// collision flags, commit pulse at frame origin.
module sprite_compositor #(
  parameter int N_SPR    = 4,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int H_OFFSET = 144,
  parameter int V_OFFSET = 35,
  parameter int BG_LEVEL = 30,
  localparam int SW  = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int NPX = SPR_W * SPR_H,
  localparam int AW  = (NPX > 1) ? $clog2(NPX) : 1
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic              active,
  input  logic [9:0]        VGA_X,
  input  logic [9:0]        VGA_Y,
  input  logic              bm_we,
  input  logic [SW-1:0]     bm_spr,
  input  logic [AW-1:0]     bm_addr,
  input  logic [2:0]        bm_rgb,
  input  logic              at_we,
  input  logic [SW-1:0]     at_spr,
  input  logic [9:0]        at_x,
  input  logic [9:0]        at_y,
  input  logic [4:0]        at_w,
  input  logic [4:0]        at_h,
  input  logic [1:0]        at_shift,
  input  logic              at_en,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic [N_SPR-1:0]  collision,
  output logic              commit
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [1:0] shift;
    logic       en;
  } attr_t;

  attr_t      shd [N_SPR];
  attr_t      act [N_SPR];
  logic [2:0] bm  [N_SPR][NPX];

  logic frame_start;
  assign frame_start = (VGA_X == 10'd0) && (VGA_Y == 10'd0);
  assign commit      = frame_start && !reset;

  // Stage 1: hit test in 11-bit two's complement; bit 10 is the sign.
  logic [10:0] vx, vy;
  logic [N_SPR-1:0][10:0] dx, dy, wl, hl;
  logic [N_SPR-1:0] hit_c;

  assign vx = {1'b0, VGA_X} - 11'(H_OFFSET);
  assign vy = {1'b0, VGA_Y} - 11'(V_OFFSET);

  always_comb begin
    dx    = '0;
    dy    = '0;
    wl    = '0;
    hl    = '0;
    hit_c = '0;
    for (int i = 0; i < N_SPR; i++) begin
      dx[i]    = vx - {1'b0, act[i].x};
      dy[i]    = vy - {1'b0, act[i].y};
      wl[i]    = 11'(act[i].w) << act[i].shift;
      hl[i]    = 11'(act[i].h) << act[i].shift;
      hit_c[i] = act[i].en
              && !dx[i][10] && !dy[i][10]
              && (dx[i] < wl[i]) && (dy[i] < hl[i])
              && (act[i].w != 5'd0) && (act[i].h != 5'd0);
    end
  end

  logic [N_SPR-1:0]         s1_hit;
  logic [N_SPR-1:0][CW-1:0] s1_lx;
  logic [N_SPR-1:0][RW-1:0] s1_ly;
  logic                     s1_blank, s1_act;

  // Stage 2: bitmap fetch and opacity.
  logic [N_SPR-1:0][2:0] rd_c;
  logic [N_SPR-1:0]      opq_c, ov_c;

  always_comb begin
    rd_c  = '0;
    opq_c = '0;
    ov_c  = '0;
    for (int i = 0; i < N_SPR; i++) begin
      rd_c[i]  = bm[i][AW'(s1_ly[i]) * AW'(SPR_W) + AW'(s1_lx[i])];
      opq_c[i] = s1_hit[i] && (rd_c[i] != 3'b000);
    end
    for (int i = 0; i < N_SPR; i++)
      ov_c[i] = opq_c[i]
             && ((opq_c & ~(N_SPR'(1) << i)) != '0);
  end

  logic [N_SPR-1:0][2:0] s2_rgb;
  logic [N_SPR-1:0]      s2_opq;
  logic                  s2_blank, s2_act;
  logic [N_SPR-1:0]      acc;

  // Stage 3: lowest index wins, so scan from the top down.
  logic [2:0] pick;
  logic       any;

  always_comb begin
    pick = 3'b000;
    any  = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (s2_opq[i]) begin
        pick = s2_rgb[i];
        any  = 1'b1;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      for (int i = 0; i < N_SPR; i++) begin
        shd[i] <= '0;
        act[i] <= '0;
        for (int j = 0; j < NPX; j++)
          bm[i][j] <= 3'b000;
      end
      s1_hit    <= '0;
      s1_lx     <= '0;
      s1_ly     <= '0;
      s1_blank  <= 1'b0;
      s1_act    <= 1'b0;
      s2_rgb    <= '0;
      s2_opq    <= '0;
      s2_blank  <= 1'b0;
      s2_act    <= 1'b0;
      acc       <= '0;
      collision <= '0;
      VGA_R     <= 8'd0;
      VGA_G     <= 8'd0;
      VGA_B     <= 8'd0;
    end else begin
      if (at_we)
        shd[at_spr] <= {at_x, at_y, at_w, at_h, at_shift, at_en};
      if (frame_start)
        for (int i = 0; i < N_SPR; i++)
          act[i] <= shd[i];
      if (bm_we)
        bm[bm_spr][bm_addr] <= bm_rgb;

      s1_hit   <= hit_c;
      s1_blank <= vx[10] | vy[10];
      s1_act   <= active;
      for (int i = 0; i < N_SPR; i++) begin
        s1_lx[i] <= CW'(dx[i] >> act[i].shift);
        s1_ly[i] <= RW'(dy[i] >> act[i].shift);
      end

      s2_rgb   <= rd_c;
      s2_opq   <= opq_c;
      s2_blank <= s1_blank;
      s2_act   <= s1_act;

      // Overlap seen on the commit cycle opens the new frame.
      if (frame_start) begin
        collision <= acc;
        acc       <= ov_c;
      end else begin
        acc <= acc | ov_c;
      end

      if (!s2_act || s2_blank) begin
        VGA_R <= 8'd0;
        VGA_G <= 8'd0;
        VGA_B <= 8'd0;
      end else if (any) begin
        VGA_R <= {8{pick[2]}};
        VGA_G <= {8{pick[1]}};
        VGA_B <= {8{pick[0]}};
      end else begin
        VGA_R <= 8'(BG_LEVEL);
        VGA_G <= 8'(BG_LEVEL);
        VGA_B <= 8'(BG_LEVEL);
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed bench for sprite_compositor.
// Drives pixels, bitmaps and attributes; checks colours, commit, collisions.
module tb_sprite_compositor;

  logic       VGA_CLK = 1'b0;
  logic       reset   = 1'b1;
  logic       active  = 1'b0;
  logic [9:0] VGA_X   = 10'd1;
  logic [9:0] VGA_Y   = 10'd1;
  logic       bm_we   = 1'b0;
  logic [1:0] bm_spr  = '0;
  logic [7:0] bm_addr = '0;
  logic [2:0] bm_rgb  = '0;
  logic       at_we   = 1'b0;
  logic [1:0] at_spr  = '0;
  logic [9:0] at_x    = '0;
  logic [9:0] at_y    = '0;
  logic [4:0] at_w    = '0;
  logic [4:0] at_h    = '0;
  logic [1:0] at_shift = '0;
  logic       at_en   = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic [3:0] collision;
  logic       commit;

  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] BG  = 24'h1E1E1E;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] WHT = 24'hFFFFFF;

  sprite_compositor dut (
    .VGA_CLK  (VGA_CLK),
    .reset    (reset),
    .active   (active),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .bm_we    (bm_we),
    .bm_spr   (bm_spr),
    .bm_addr  (bm_addr),
    .bm_rgb   (bm_rgb),
    .at_we    (at_we),
    .at_spr   (at_spr),
    .at_x     (at_x),
    .at_y     (at_y),
    .at_w     (at_w),
    .at_h     (at_h),
    .at_shift (at_shift),
    .at_en    (at_en),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .collision(collision),
    .commit   (commit)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge VGA_CLK);
    #1;
  endtask

  function automatic logic [31:0] rgb_out();
    return {8'h00, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic park();
    VGA_X  = 10'd1;
    VGA_Y  = 10'd1;
    active = 1'b1;
  endtask

  task automatic wr_bm(input int s, input int a, input logic [2:0] c);
    bm_spr  = 2'(s);
    bm_addr = 8'(a);
    bm_rgb  = c;
    bm_we   = 1'b1;
    step();
    bm_we   = 1'b0;
  endtask

  task automatic set_attr(input int s, input int x, input int y,
                          input int w, input int h, input int sh,
                          input logic en);
    at_spr   = 2'(s);
    at_x     = 10'(x);
    at_y     = 10'(y);
    at_w     = 5'(w);
    at_h     = 5'(h);
    at_shift = 2'(sh);
    at_en    = en;
  endtask

  task automatic wr_attr(input int s, input int x, input int y,
                         input int w, input int h, input int sh,
                         input logic en);
    set_attr(s, x, y, w, h, sh, en);
    at_we = 1'b1;
    step();
    at_we = 1'b0;
  endtask

  // Two parked cycles first so stage 2 never carries a probe pixel
  // into the commit cycle.
  task automatic do_commit(input string tag, input logic aw);
    park();
    step();
    step();
    VGA_X = 10'd0;
    VGA_Y = 10'd0;
    at_we = aw;
    #1;
    check(tag, 32'(commit), 32'd1);
    step();
    at_we = 1'b0;
    park();
    #1;
    check({tag, "_off"}, 32'(commit), 32'd0);
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic a, input logic [23:0] exp);
    VGA_X  = 10'(x);
    VGA_Y  = 10'(y);
    active = a;
    repeat (3) step();
    check(tag, rgb_out(), {8'h00, exp});
    park();
  endtask

  initial begin
    step();
    step();
    check("rst_rgb", rgb_out(), 32'd0);
    check("rst_col", 32'(collision), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    reset  = 1'b0;
    active = 1'b1;

    // single red sprite on layer 0
    wr_bm(0, 0, 3'b100);
    wr_bm(0, 1, 3'b100);
    wr_bm(0, 16, 3'b100);
    wr_bm(0, 17, 3'b100);
    wr_attr(0, 10, 5, 2, 2, 0, 1'b1);
    probe("pre_commit", 154, 40, 1'b1, BG);
    do_commit("commit1", 1'b0);
    probe("red_tl", 154, 40, 1'b1, RED);
    probe("red_br", 155, 41, 1'b1, RED);
    probe("right_edge", 156, 40, 1'b1, BG);
    probe("left_edge", 153, 40, 1'b1, BG);

    // latency: exactly 3 edges
    VGA_X = 10'd154;
    VGA_Y = 10'd40;
    step();
    step();
    check("lat2", rgb_out(), {8'h00, BG});
    step();
    check("lat3", rgb_out(), {8'h00, RED});
    park();

    // blanking
    probe("inactive", 154, 40, 1'b0, BLK);
    probe("vx_neg", 100, 40, 1'b1, BLK);
    probe("vy_neg", 154, 10, 1'b1, BLK);

    // priority and collision
    for (int a = 0; a < 2; a++) begin
      wr_bm(0, a, 3'b010);
      wr_bm(0, a + 16, 3'b010);
      wr_bm(1, a, 3'b001);
      wr_bm(1, a + 16, 3'b001);
    end
    wr_attr(1, 10, 5, 2, 2, 0, 1'b1);
    do_commit("commitA", 1'b0);
    check("colA", 32'(collision), 32'd0);
    probe("prio_tl", 154, 40, 1'b1, GRN);
    probe("prio_br", 155, 41, 1'b1, GRN);
    do_commit("commitB", 1'b0);
    check("colB", 32'(collision), 32'b0011);

    // move layer 1 mid-frame: old placement holds until commit
    wr_attr(1, 100, 5, 2, 2, 0, 1'b1);
    probe("held_new", 244, 40, 1'b1, BG);
    probe("held_old", 154, 40, 1'b1, GRN);
    do_commit("commitC", 1'b0);
    check("colC", 32'(collision), 32'b0011);
    probe("moved_new", 244, 40, 1'b1, BLU);
    probe("moved_l0", 154, 40, 1'b1, GRN);

    // attribute write on the commit cycle lands a frame later
    set_attr(1, 200, 5, 2, 2, 0, 1'b1);
    do_commit("commitD", 1'b1);
    check("colD", 32'(collision), 32'd0);
    probe("late_old", 244, 40, 1'b1, BLU);
    probe("late_new0", 344, 40, 1'b1, BG);
    do_commit("commitE", 1'b0);
    probe("late_new1", 344, 40, 1'b1, BLU);
    probe("late_gone", 244, 40, 1'b1, BG);

    // scaling: one pixel at shift 2 covers 4x4
    wr_bm(2, 0, 3'b111);
    wr_attr(2, 300, 100, 1, 1, 2, 1'b1);
    do_commit("commitF", 1'b0);
    probe("sc_dx0", 444, 135, 1'b1, WHT);
    probe("sc_dx3", 447, 135, 1'b1, WHT);
    probe("sc_dx4", 448, 135, 1'b1, BG);
    probe("sc_dxm1", 443, 135, 1'b1, BG);
    probe("sc_dy3", 444, 138, 1'b1, WHT);
    probe("sc_dy4", 444, 139, 1'b1, BG);

    // reset mid-frame
    VGA_X = 10'd444;
    VGA_Y = 10'd135;
    repeat (3) step();
    check("pre_rst", rgb_out(), {8'h00, WHT});
    reset = 1'b1;
    step();
    check("mid_rst_rgb", rgb_out(), 32'd0);
    reset = 1'b0;
    check("mid_rst_col", 32'(collision), 32'd0);
    probe("post_rst_l2", 444, 135, 1'b1, BG);
    probe("post_rst_l1", 344, 40, 1'b1, BG);
    do_commit("commitG", 1'b0);
    probe("post_rst_cm", 444, 135, 1'b1, BG);
    wr_attr(2, 300, 100, 1, 1, 2, 1'b1);
    do_commit("commitH", 1'b0);
    probe("bm_cleared", 444, 135, 1'b1, BG);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
